// File: rtl/register_file.sv
// register_file: N = 2**SEL_W general-purpose registers of W bits with two read
// ports (x, y), one write port (z) and a per-register busy scoreboard.
//
// Ports:
//   clock, reset (async, active-low)
//   z_in/z_enb/z_sel        write port; a write clears the busy bit of z_sel
//   lock_enb/lock_sel       sets the busy bit of lock_sel (wins over a same-cycle write)
//   x_enb/x_sel/x_out/x_valid  read port x; 1-cycle latency, stalls while busy
//   y_enb/y_sel/y_out/y_valid  read port y; same behaviour as x
//   busy                    registered scoreboard, bit i = r[i] locked
module register_file #(
    parameter int unsigned W        = 8,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [W-1:0]     z_in,
    input  logic             z_enb,
    input  logic [SEL_W-1:0] z_sel,
    input  logic             lock_enb,
    input  logic [SEL_W-1:0] lock_sel,
    input  logic             x_enb,
    input  logic [SEL_W-1:0] x_sel,
    output logic [W-1:0]     x_out,
    output logic             x_valid,
    input  logic             y_enb,
    input  logic [SEL_W-1:0] y_sel,
    output logic [W-1:0]     y_out,
    output logic             y_valid,
    output logic [(2**SEL_W)-1:0] busy
);

    localparam int unsigned N      = 2 ** SEL_W;
    localparam bit          ZR_EN  = (ZERO_REG != 0);
    localparam bit          BYP_EN = (BYPASS != 0);

    logic [W-1:0] r_mem [N];
    logic [N-1:0] r_busy;
    logic [W-1:0] r_x_out;
    logic [W-1:0] r_y_out;
    logic         r_x_valid;
    logic         r_y_valid;

    logic         w_z_eff;
    logic         w_lock_eff;
    logic [N-1:0] w_busy_nxt;
    logic         w_x_byp;
    logic         w_y_byp;
    logic         w_x_acc;
    logic         w_y_acc;
    logic [W-1:0] w_x_data;
    logic [W-1:0] w_y_data;

    // Effective write/lock strobes, scoreboard update and read accept/data selection.
    // r0 is never written when ZERO_REG is set, so it keeps its reset value of zero
    // and a write aimed at r0 is also never forwarded.
    always_comb begin
        w_z_eff    = z_enb && !(ZR_EN && (z_sel == '0));
        w_lock_eff = lock_enb && !(ZR_EN && (lock_sel == '0));

        w_busy_nxt = r_busy;
        if (w_z_eff) begin
            w_busy_nxt[z_sel] = 1'b0;
        end
        if (w_lock_eff) begin
            w_busy_nxt[lock_sel] = 1'b1;
        end

        // Accept decisions use the pre-lock scoreboard.
        w_x_byp  = BYP_EN && w_z_eff && (z_sel == x_sel);
        w_y_byp  = BYP_EN && w_z_eff && (z_sel == y_sel);
        w_x_acc  = x_enb && (!r_busy[x_sel] || w_x_byp);
        w_y_acc  = y_enb && (!r_busy[y_sel] || w_y_byp);
        w_x_data = w_x_byp ? z_in : r_mem[x_sel];
        w_y_data = w_y_byp ? z_in : r_mem[y_sel];
    end

    // Register array, scoreboard and read-port output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N); i++) begin
                r_mem[i] <= '0;
            end
            r_busy    <= '0;
            r_x_out   <= '0;
            r_y_out   <= '0;
            r_x_valid <= 1'b0;
            r_y_valid <= 1'b0;
        end else begin
            if (w_z_eff) begin
                r_mem[z_sel] <= z_in;
            end
            r_busy <= w_busy_nxt;
            if (w_x_acc) begin
                r_x_out <= w_x_data;
            end
            if (w_y_acc) begin
                r_y_out <= w_y_data;
            end
            r_x_valid <= w_x_acc;
            r_y_valid <= w_y_acc;
        end
    end

    assign x_out   = r_x_out;
    assign y_out   = r_y_out;
    assign x_valid = r_x_valid;
    assign y_valid = r_y_valid;
    assign busy    = r_busy;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table, a reset-mid-stall sequence and a random
// phase checked cycle by cycle against an array-based reference model.
module tb_register_file;

    localparam int unsigned W     = 8;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned N     = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [W-1:0]     z_in;
    logic             z_enb;
    logic [SEL_W-1:0] z_sel;
    logic             lock_enb;
    logic [SEL_W-1:0] lock_sel;
    logic             x_enb;
    logic [SEL_W-1:0] x_sel;
    logic [W-1:0]     x_out;
    logic             x_valid;
    logic             y_enb;
    logic [SEL_W-1:0] y_sel;
    logic [W-1:0]     y_out;
    logic             y_valid;
    logic [N-1:0]     busy;

    register_file #(.W(W), .SEL_W(SEL_W), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock(clock), .reset(reset),
        .z_in(z_in), .z_enb(z_enb), .z_sel(z_sel),
        .lock_enb(lock_enb), .lock_sel(lock_sel),
        .x_enb(x_enb), .x_sel(x_sel), .x_out(x_out), .x_valid(x_valid),
        .y_enb(y_enb), .y_sel(y_sel), .y_out(y_out), .y_valid(y_valid),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed vector: inputs for one cycle and outputs expected after its posedge.
    typedef struct {
        int ze; int zs; int zi;
        int le; int ls;
        int xe; int xs;
        int ye; int ys;
        int exo; int exv;
        int eyo; int eyv;
        int eb;
    } vec_t;

    vec_t tbl [17];

    // Reference model state: register contents and lock flags as plain arrays.
    int m_mem  [N];
    bit m_busy [N];
    int m_xo, m_yo;
    bit m_xv, m_yv;

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_mem[i]  = 0;
            m_busy[i] = 1'b0;
        end
        m_xo = 0; m_yo = 0; m_xv = 1'b0; m_yv = 1'b0;
    endtask

    // Read result for one port using the current (pre-edge) model state.
    task automatic model_read(input bit en, input int sel, inout int o, output bit v);
        bit fwd;
        fwd = z_enb && (int'(z_sel) == sel) && (sel != 0);
        v   = en && (!m_busy[sel] || fwd);
        if (v) o = (sel == 0) ? 0 : (fwd ? int'(z_in) : m_mem[sel]);
    endtask

    task automatic model_step();
        model_read(x_enb, int'(x_sel), m_xo, m_xv);
        model_read(y_enb, int'(y_sel), m_yo, m_yv);
        if (z_enb && z_sel != 0) begin
            m_mem[z_sel]  = int'(z_in);
            m_busy[z_sel] = 1'b0;
        end
        if (lock_enb && lock_sel != 0) m_busy[lock_sel] = 1'b1;
    endtask

    function automatic int model_busy_vec();
        int b = 0;
        for (int i = 0; i < int'(N); i++) if (m_busy[i]) b |= (1 << i);
        return b;
    endfunction

    task automatic idle_inputs();
        z_enb = 1'b0; z_sel = '0; z_in = '0;
        lock_enb = 1'b0; lock_sel = '0;
        x_enb = 1'b0; x_sel = '0;
        y_enb = 1'b0; y_sel = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tbl[0]  = '{0,0,0,     0,0, 1,5, 0,0, 'h00,1, 'h00,0, 'h0000};
        tbl[1]  = '{1,3,'hA5,  0,0, 0,0, 0,0, 'h00,0, 'h00,0, 'h0000};
        tbl[2]  = '{0,0,0,     0,0, 1,3, 0,0, 'hA5,1, 'h00,0, 'h0000};
        tbl[3]  = '{0,0,0,     1,4, 0,0, 0,0, 'hA5,0, 'h00,0, 'h0010};
        tbl[4]  = '{0,0,0,     0,0, 1,4, 0,0, 'hA5,0, 'h00,0, 'h0010};
        tbl[5]  = '{0,0,0,     0,0, 1,4, 0,0, 'hA5,0, 'h00,0, 'h0010};
        tbl[6]  = '{0,0,0,     0,0, 1,4, 0,0, 'hA5,0, 'h00,0, 'h0010};
        tbl[7]  = '{1,4,'h3C,  0,0, 1,4, 0,0, 'h3C,1, 'h00,0, 'h0000};
        tbl[8]  = '{1,2,'h11,  0,0, 0,0, 0,0, 'h3C,0, 'h00,0, 'h0000};
        tbl[9]  = '{1,2,'h22,  0,0, 1,2, 1,2, 'h22,1, 'h22,1, 'h0000};
        tbl[10] = '{1,0,'hFF,  1,0, 0,0, 0,0, 'h22,0, 'h22,0, 'h0000};
        tbl[11] = '{0,0,0,     0,0, 1,0, 1,2, 'h00,1, 'h22,1, 'h0000};
        tbl[12] = '{0,0,0,     1,9, 1,9, 0,0, 'h00,1, 'h22,0, 'h0200};
        tbl[13] = '{1,9,'h77,  1,9, 0,0, 1,1, 'h00,0, 'h00,1, 'h0200};
        tbl[14] = '{0,0,0,     0,0, 1,9, 0,0, 'h00,0, 'h00,0, 'h0200};
        tbl[15] = '{1,9,'h55,  0,0, 0,0, 0,0, 'h00,0, 'h00,0, 'h0000};
        tbl[16] = '{0,0,0,     0,0, 1,9, 0,0, 'h55,1, 'h00,0, 'h0000};

        // Reset state.
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_x_out",   32'(x_out),   0);
        check("rst_x_valid", 32'(x_valid), 0);
        check("rst_y_valid", 32'(y_valid), 0);
        check("rst_busy",    32'(busy),    0);
        @(negedge clock);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            z_enb    = 1'(tbl[i].ze); z_sel = SEL_W'(tbl[i].zs); z_in = W'(tbl[i].zi);
            lock_enb = 1'(tbl[i].le); lock_sel = SEL_W'(tbl[i].ls);
            x_enb    = 1'(tbl[i].xe); x_sel = SEL_W'(tbl[i].xs);
            y_enb    = 1'(tbl[i].ye); y_sel = SEL_W'(tbl[i].ys);
            step();
            check($sformatf("vec%0d_x_out", i),   32'(x_out),   32'(tbl[i].exo));
            check($sformatf("vec%0d_x_valid", i), 32'(x_valid), 32'(tbl[i].exv));
            check($sformatf("vec%0d_y_out", i),   32'(y_out),   32'(tbl[i].eyo));
            check($sformatf("vec%0d_y_valid", i), 32'(y_valid), 32'(tbl[i].eyv));
            check($sformatf("vec%0d_busy", i),    32'(busy),    32'(tbl[i].eb));
        end

        // Reset in the middle of a stalled read on a locked register.
        idle_inputs();
        lock_enb = 1'b1; lock_sel = 4'd7;
        step();
        check("stall_lock_busy", 32'(busy), 32'h0080);
        idle_inputs();
        x_enb = 1'b1; x_sel = 4'd7;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_x_valid", 32'(x_valid), 0);
        end
        check("stall_x_out_held", 32'(x_out), 32'h55);
        #2 reset = 1'b0;
        #1;
        check("midrst_x_valid", 32'(x_valid), 0);
        check("midrst_busy",    32'(busy),    0);
        check("midrst_x_out",   32'(x_out),   0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("postrst_x_valid", 32'(x_valid), 1);
        check("postrst_x_out",   32'(x_out),   0);

        // Random phase against the reference model.
        idle_inputs();
        reset = 1'b0;
        #2;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 600; c++) begin
            z_enb    = 1'($urandom_range(0, 1));
            z_sel    = SEL_W'($urandom_range(0, 7));
            z_in     = W'($urandom);
            lock_enb = ($urandom_range(0, 3) == 0);
            lock_sel = SEL_W'($urandom_range(0, 7));
            x_enb    = ($urandom_range(0, 3) != 0);
            x_sel    = SEL_W'($urandom_range(0, 7));
            y_enb    = ($urandom_range(0, 3) != 0);
            y_sel    = SEL_W'($urandom_range(0, 7));
            model_step();
            step();
            check("rnd_x_valid", 32'(x_valid), 32'(m_xv));
            check("rnd_x_out",   32'(x_out),   32'(m_xo));
            check("rnd_y_valid", 32'(y_valid), 32'(m_yv));
            check("rnd_y_out",   32'(y_out),   32'(m_yo));
            check("rnd_busy",    32'(busy),    32'(model_busy_vec()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
